// File: rtl/adsr_pkg.sv
// Shared types and default widths for the ADSR envelope generator.
// Optional feature macro: ADSR_HARD_RETRIG_EN.
package adsr_pkg;

    localparam int ADSR_RATE_W  = 16;
    localparam int ADSR_LEVEL_W = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_rate_prescaler.sv
// Loadable down-counter; tick marks count==0 while enabled.
// A load takes priority over counting so the owner can reload on tick.
module adsr_rate_prescaler #(
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [RATE_W-1:0] load_value,
    input  logic              enable,
    output logic              tick
);

    logic [RATE_W-1:0] count_q;
    logic [RATE_W-1:0] count_d;

    assign tick = enable && (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: gate + velocity in, 7-bit volume out.
// ADSR_HARD_RETRIG_EN: a new note restarts the level from zero.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int RATE_W  = ADSR_RATE_W,
    parameter int LEVEL_W = ADSR_LEVEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               gate,
    input  logic [LEVEL_W-1:0] velocity,
    input  logic [RATE_W-1:0]  attack_rate,
    input  logic [RATE_W-1:0]  decay_rate,
    input  logic [LEVEL_W-1:0] sustain_level,
    input  logic [RATE_W-1:0]  release_rate,
    output logic [LEVEL_W-1:0] volume,
    output logic               active,
    output logic [2:0]         stage
);

    adsr_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] peak_q, peak_d;
    logic               gate_q;
    logic               active_q, active_d;

    logic               rise, fall;
    logic [LEVEL_W-1:0] target;
    logic               pre_load;
    logic [RATE_W-1:0]  pre_value;
    logic               pre_en;
    logic               tick;

    assign rise   = gate & ~gate_q;
    assign fall   = ~gate & gate_q;
    assign target = (sustain_level < peak_q) ? sustain_level : peak_q;
    assign pre_en = (state_q == ATTACK) || (state_q == DECAY) ||
                    (state_q == RELEASE);

    adsr_rate_prescaler #(
        .RATE_W(RATE_W)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .load      (pre_load),
        .load_value(pre_value),
        .enable    (pre_en),
        .tick      (tick)
    );

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        peak_d    = peak_q;
        pre_load  = 1'b0;
        pre_value = attack_rate;

        if (rise) begin
            state_d   = ATTACK;
            peak_d    = velocity;
            pre_load  = 1'b1;
            pre_value = attack_rate;
`ifdef ADSR_HARD_RETRIG_EN
            level_d   = '0;
`else
            level_d   = level_q;
`endif
        end else if (fall && (state_q == ATTACK || state_q == DECAY ||
                              state_q == SUSTAIN)) begin
            state_d   = RELEASE;
            pre_load  = 1'b1;
            pre_value = release_rate;
        end else begin
            unique case (state_q)
                ATTACK: begin
                    if (level_q >= peak_q) begin
                        state_d   = DECAY;
                        pre_load  = 1'b1;
                        pre_value = decay_rate;
                    end else if (tick) begin
                        level_d   = level_q + 1'b1;
                        pre_load  = 1'b1;
                        pre_value = attack_rate;
                    end
                end
                DECAY: begin
                    if (level_q <= target) begin
                        state_d = SUSTAIN;
                    end else if (tick) begin
                        level_d   = level_q - 1'b1;
                        pre_load  = 1'b1;
                        pre_value = decay_rate;
                    end
                end
                RELEASE: begin
                    if (level_q == '0) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        level_d   = level_q - 1'b1;
                        pre_load  = 1'b1;
                        pre_value = release_rate;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            level_q  <= '0;
            peak_q   <= '0;
            gate_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            peak_q   <= peak_d;
            gate_q   <= gate;
            active_q <= active_d;
        end
    end

    assign volume = level_q;
    assign active = active_q;
    assign stage  = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Randomized bench for adsr_envelope against a timestamp-based model.
// Honours ADSR_HARD_RETRIG_EN the same way the design does.
module tb_adsr_envelope;

    logic        clk = 1'b0;
    logic        reset;
    logic        gate;
    logic [6:0]  velocity;
    logic [15:0] attack_rate;
    logic [15:0] decay_rate;
    logic [6:0]  sustain_level;
    logic [15:0] release_rate;
    logic [6:0]  volume;
    logic        active;
    logic [2:0]  stage;

    int n_chk  = 0;
    int n_pass = 0;
    longint cyc_n = 0;

    // Reference model: phase numbers follow the published stage encoding.
    int     m_phase;
    int     m_level;
    int     m_peak;
    longint m_due;
    bit     m_prev_gate;

`ifdef ADSR_HARD_RETRIG_EN
    localparam bit HARD = 1'b1;
`else
    localparam bit HARD = 1'b0;
`endif

    always #5 clk = ~clk;

    adsr_envelope dut (
        .clk          (clk),
        .reset        (reset),
        .gate         (gate),
        .velocity     (velocity),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .volume       (volume),
        .active       (active),
        .stage        (stage)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                      tag, obs, exp, cyc_n);
    endtask

    // Next step is scheduled as an absolute cycle number: entry/step + rate + 1.
    task automatic model_edge();
        bit rise, fall;
        int tgt;
        rise = gate && !m_prev_gate;
        fall = !gate && m_prev_gate;
        if (reset) begin
            m_phase = 0; m_level = 0; m_peak = 0; m_due = 0;
            m_prev_gate = 0;
            return;
        end
        m_prev_gate = gate;
        if (rise) begin
            m_peak  = int'(velocity);
            m_phase = 1;
            if (HARD) m_level = 0;
            m_due   = cyc_n + longint'(attack_rate) + 1;
        end else if (fall && m_phase >= 1 && m_phase <= 3) begin
            m_phase = 4;
            m_due   = cyc_n + longint'(release_rate) + 1;
        end else if (m_phase == 1) begin
            if (m_level >= m_peak) begin
                m_phase = 2;
                m_due   = cyc_n + longint'(decay_rate) + 1;
            end else if (cyc_n == m_due) begin
                m_level++;
                m_due = cyc_n + longint'(attack_rate) + 1;
            end
        end else if (m_phase == 2) begin
            tgt = (int'(sustain_level) < m_peak) ? int'(sustain_level) : m_peak;
            if (m_level <= tgt) m_phase = 3;
            else if (cyc_n == m_due) begin
                m_level--;
                m_due = cyc_n + longint'(decay_rate) + 1;
            end
        end else if (m_phase == 4) begin
            if (m_level == 0) m_phase = 0;
            else if (cyc_n == m_due) begin
                m_level--;
                m_due = cyc_n + longint'(release_rate) + 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        cyc_n++;
        model_edge();
        #1;
        chk("volume", int'(volume), m_level);
        chk("stage", int'(stage), m_phase);
        chk("active", int'(active), int'(m_phase != 0));
    endtask

    initial begin
        reset = 1'b1; gate = 1'b0; velocity = 7'd8;
        attack_rate = 16'd3; decay_rate = 16'd0;
        sustain_level = 7'd5; release_rate = 16'd1;
        m_phase = 0; m_level = 0; m_peak = 0; m_due = 0; m_prev_gate = 0;

        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_volume", int'(volume), 0);
        chk("rst_stage", int'(stage), 0);
        repeat (100) cyc();
        chk("idle_active", int'(active), 0);

        // Attack 1..8 every 4 edges, decay 7,6,5, hold sustain.
        gate = 1'b1;
        cyc();
        chk("atk_enter", int'(stage), 1);
        repeat (4) cyc();
        chk("atk_e4", int'(volume), 1);
        repeat (28) cyc();
        chk("atk_e32", int'(volume), 8);
        cyc();
        chk("dec_e33", int'(stage), 2);
        repeat (3) cyc();
        chk("dec_e36", int'(volume), 5);
        cyc();
        chk("sus_enter", int'(stage), 3);
        repeat (50) cyc();
        chk("sus_hold", int'(volume), 5);

        // Release 4..0 every 2 edges, then idle.
        gate = 1'b0;
        cyc();
        chk("rel_enter", int'(stage), 4);
        repeat (2) cyc();
        chk("rel_f2", int'(volume), 4);
        repeat (8) cyc();
        chk("rel_f10", int'(volume), 0);
        cyc();
        chk("rel_idle", int'(active), 0);

        // Retrigger from release at level 3.
        gate = 1'b1;
        repeat (40) cyc();
        gate = 1'b0;
        cyc();
        repeat (4) cyc();
        chk("retrig_pre", int'(volume), 3);
        gate = 1'b1;
        cyc();
        chk("retrig_stage", int'(stage), 1);
        chk("retrig_lvl", int'(volume), HARD ? 0 : 3);
        repeat (4) cyc();
        chk("retrig_step", int'(volume), HARD ? 1 : 4);

        // Velocity 0 settles in sustain at 0.
        gate = 1'b0;
        repeat (20) cyc();
        velocity = 7'd0;
        gate = 1'b1;
        repeat (3) cyc();
        chk("vel0_stage", int'(stage), 3);
        chk("vel0_vol", int'(volume), 0);

        // Sustain above peak clips to peak.
        gate = 1'b0;
        repeat (20) cyc();
        sustain_level = 7'd100; velocity = 7'd8; attack_rate = 16'd0;
        gate = 1'b1;
        repeat (20) cyc();
        chk("susclip_stage", int'(stage), 3);
        chk("susclip_vol", int'(volume), 8);

        // Randomized traffic, including gate held through reset.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 59) == 0) gate = ~gate;
            if ($urandom_range(0, 99) == 0) begin
                attack_rate  = 16'($urandom_range(0, 3));
                decay_rate   = 16'($urandom_range(0, 3));
                release_rate = 16'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 29) == 0) velocity = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 49) == 0) sustain_level = 7'($urandom_range(0, 127));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
